// File: rtl/counter_array_ctrl.sv
// counter_array_ctrl
//   NUM_CH counters run under one IDLE/RUN/HOLD sequencer. Each channel
//   counts for its own programmable number of cycles per run, and a
//   loadw-strobed stage registers the sum of all channel counts.
//   Every register updates on the falling edge of clk.
//
// Ports
//   clk    in   system clock (state changes on the falling edge)
//   rst    in   asynchronous, active-high reset
//   start  in   request a new run; accepted in IDLE or HOLD
//   len    in   packed per-channel run lengths, channel i at [i*LEN_W +: LEN_W]
//   loadw  in   when high at an edge, sum takes the pre-edge count total
//   count  out  packed channel counters, channel i at [i*WIDTH +: WIDTH]
//   sum    out  registered sum of all channel counts
//   busy   out  high while the sequencer is in RUN
//   done   out  one-cycle pulse at the end of a run

module counter_array_ctrl #(
  parameter int WIDTH    = 4,
  parameter int NUM_CH   = 2,
  parameter int LEN_W    = 4,
  parameter int SATURATE = 0,
  localparam int SUM_W   = WIDTH + $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH*LEN_W-1:0] len,
  input  logic                    loadw,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [SUM_W-1:0]        sum,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [LEN_W-1:0] r_lenQ  [NUM_CH];
  logic [LEN_W-1:0] r_maxQ;
  logic [LEN_W-1:0] r_step;
  logic [WIDTH-1:0] r_count [NUM_CH];
  logic [SUM_W-1:0] r_sum;
  logic             r_done;

  logic [LEN_W-1:0] w_lenMax;
  logic [WIDTH-1:0] w_countInc [NUM_CH];
  logic [SUM_W-1:0] w_countSum;
  logic             w_accept;
  logic             w_runLast;

  // Largest requested length decides how long the run lasts; computed
  // from the live len input so it can be captured alongside it.
  always_comb begin
    w_lenMax = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (len[i*LEN_W +: LEN_W] > w_lenMax) begin
        w_lenMax = len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Start is only honoured outside RUN; the last RUN cycle is the one
  // whose step is one short of the longest length. The compare is done
  // one bit wider so step+1 never wraps.
  assign w_accept  = (r_state != RUN) && start;
  assign w_runLast = (r_state == RUN) &&
                     (({1'b0, r_step} + (LEN_W+1)'(1)) == {1'b0, r_maxQ});

  // State register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A run with every length zero skips RUN entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, HOLD: begin
        if (start) begin
          w_nextState = (w_lenMax == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (w_runLast) begin
          w_nextState = HOLD;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from the state register and the done flop.
  always_comb begin
    busy = (r_state == RUN);
    done = r_done;
  end

  // Per-channel increment, optionally sticking at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if ((SATURATE != 0) && (&r_count[i])) begin
        w_countInc[i] = r_count[i];
      end else begin
        w_countInc[i] = r_count[i] + WIDTH'(1);
      end
    end
  end

  // Zero-extended total of all counters, wide enough never to overflow.
  always_comb begin
    w_countSum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_countSum = w_countSum + SUM_W'(r_count[i]);
    end
  end

  // Datapath: capture on accepted start, count while in RUN. done is
  // raised only on the edge that enters HOLD from RUN or from a
  // zero-length start, so it lasts exactly one cycle.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_maxQ <= '0;
      r_step <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_lenQ[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      r_done <= (w_nextState == HOLD) && ((r_state == RUN) || w_accept);
      if (w_accept) begin
        r_maxQ <= w_lenMax;
        r_step <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          r_lenQ[i]  <= len[i*LEN_W +: LEN_W];
          r_count[i] <= '0;
        end
      end else if (r_state == RUN) begin
        r_step <= r_step + LEN_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_step < r_lenQ[i]) begin
            r_count[i] <= w_countInc[i];
          end
        end
      end
    end
  end

  // Sum stage runs independently of the sequencer and always sees the
  // counts as they were before the edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (loadw) begin
      r_sum <= w_countSum;
    end
  end

  assign sum = r_sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign count[g*WIDTH +: WIDTH] = r_count[g];
  end

endmodule

// File: tb/tb_counter_array_ctrl.sv
// Bench for counter_array_ctrl. The main instance (default parameters)
// is followed cycle by cycle against a small behavioural model whose
// expected outputs are queued when stimulus is driven and popped when
// the outputs are sampled. Two extra instances (LEN_W=5, wrap and
// saturate) cover counter overflow.

module tb_counter_array_ctrl;

  logic       clk = 1'b1;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       loadw;
  logic [7:0] count;
  logic [4:0] sum;
  logic       busy;
  logic       done;

  logic       startB;
  logic [9:0] lenB;
  logic       loadwB;
  logic [7:0] countB, countC;
  logic [4:0] sumB, sumC;
  logic       busyB, doneB, busyC, doneC;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] count;
    logic [4:0] sum;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sbq[$];

  // Behavioural model state: 0 idle, 1 run, 2 hold.
  int mState;
  int mElapsed;
  int mLen[2];
  int mMax;
  bit mDone;
  int mSum;

  counter_array_ctrl #(.WIDTH(4), .NUM_CH(2), .LEN_W(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .loadw(loadw),
    .count(count), .sum(sum), .busy(busy), .done(done)
  );

  counter_array_ctrl #(.WIDTH(4), .NUM_CH(2), .LEN_W(5), .SATURATE(0)) dutWrap (
    .clk(clk), .rst(rst), .start(startB), .len(lenB), .loadw(loadwB),
    .count(countB), .sum(sumB), .busy(busyB), .done(doneB)
  );

  counter_array_ctrl #(.WIDTH(4), .NUM_CH(2), .LEN_W(5), .SATURATE(1)) dutSat (
    .clk(clk), .rst(rst), .start(startB), .len(lenB), .loadw(loadwB),
    .count(countC), .sum(sumC), .busy(busyC), .done(doneC)
  );

  // Falling edge is the active edge; outputs are sampled on the rising edge.
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mCount(input int i);
    return (mElapsed < mLen[i]) ? mElapsed : mLen[i];
  endfunction

  task automatic pushExpected();
    exp_t e;
    int   c0, c1;
    c0 = mCount(0);
    c1 = mCount(1);
    e.count = {c1[3:0], c0[3:0]};
    e.sum   = mSum[4:0];
    e.busy  = (mState == 1);
    e.done  = mDone;
    sbq.push_back(e);
  endtask

  task automatic modelReset();
    mState   = 0;
    mElapsed = 0;
    mLen[0]  = 0;
    mLen[1]  = 0;
    mMax     = 0;
    mDone    = 0;
    mSum     = 0;
  endtask

  // One active edge of the model: count = min(elapsed cycles, length).
  task automatic modelEdge(input bit st, input logic [7:0] lv, input bit ld);
    int pre;
    pre = mCount(0) + mCount(1);
    if (ld) mSum = pre;
    if (mState != 1 && st) begin
      mLen[0]  = int'(lv[3:0]);
      mLen[1]  = int'(lv[7:4]);
      mMax     = (mLen[0] > mLen[1]) ? mLen[0] : mLen[1];
      mElapsed = 0;
      if (mMax == 0) begin
        mState = 2;
        mDone  = 1;
      end else begin
        mState = 1;
        mDone  = 0;
      end
    end else if (mState == 1) begin
      mElapsed++;
      if (mElapsed == mMax) begin
        mState = 2;
        mDone  = 1;
      end else begin
        mDone = 0;
      end
    end else begin
      mDone = 0;
    end
  endtask

  task automatic compareFront();
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput("sbq_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      checkOutput("count0", 32'(count[3:0]), 32'(e.count[3:0]));
      checkOutput("count1", 32'(count[7:4]), 32'(e.count[7:4]));
      checkOutput("sum",    32'(sum),        32'(e.sum));
      checkOutput("busy",   32'(busy),       32'(e.busy));
      checkOutput("done",   32'(done),       32'(e.done));
    end
  endtask

  // Drive one cycle: inputs set while clk is high, model stepped and the
  // expectation queued, then the falling edge, then sample on the rise.
  task automatic applyStimulus(input bit st, input logic [7:0] lv, input bit ld);
    start = st;
    len   = lv;
    loadw = ld;
    modelEdge(st, lv, ld);
    pushExpected();
    @(negedge clk);
    @(posedge clk);
    compareFront();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    len    = '0;
    loadw  = 1'b0;
    startB = 1'b0;
    lenB   = '0;
    loadwB = 1'b0;
    modelReset();

    // Reset state.
    #12;
    pushExpected();
    compareFront();
    checkOutput("wrap_count_rst", 32'(countB), 32'd0);
    #1 rst = 1'b0;

    // Basic run, ch0=9 ch1=4; len wiggles during the run are ignored.
    applyStimulus(1'b1, {4'd4, 4'd9}, 1'b0);
    while (mState == 1) applyStimulus(1'b0, 8'($urandom), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Overflow: ch0=20 on the LEN_W=5 instances, wrap versus saturate.
    startB = 1'b1;
    lenB   = {5'd3, 5'd20};
    applyStimulus(1'b0, 8'h00, 1'b0);
    startB = 1'b0;
    lenB   = '0;
    repeat (19) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wrap_count0_19", 32'(countB[3:0]), 32'd3);
    checkOutput("wrap_busy_19",   32'(busyB),       32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wrap_count0",    32'(countB[3:0]), 32'd4);
    checkOutput("wrap_count1",    32'(countB[7:4]), 32'd3);
    checkOutput("wrap_done",      32'(doneB),       32'd1);
    checkOutput("wrap_busy",      32'(busyB),       32'd0);
    checkOutput("sat_count0",     32'(countC[3:0]), 32'd15);
    checkOutput("sat_count1",     32'(countC[7:4]), 32'd3);
    checkOutput("sat_done",       32'(doneC),       32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wrap_done_clr",  32'(doneB),       32'd0);

    // All lengths zero: done next cycle, no busy, counts cleared.
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Start mid-run ignored; restart from HOLD on the done cycle.
    applyStimulus(1'b1, {4'd6, 4'd7}, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    while (mState == 1) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, {4'd5, 4'd2}, 1'b0);
    while (mState == 1) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Asynchronous reset between edges at step 3, with a nonzero sum.
    applyStimulus(1'b1, {4'd8, 4'd8}, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    modelReset();
    pushExpected();
    compareFront();
    #1 rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    // loadw held high across a run, ch0=3 ch1=1: sum lags counts by one edge.
    applyStimulus(1'b1, {4'd1, 4'd3}, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_array_ctrl.md
Name: counter_array_ctrl

Overview:
- Parametrised, multi-channel successor to the two-counter-plus-controller block.
- NUM_CH counters run under one sequencing FSM. Each channel counts for its own programmable number of cycles per run.
- A start/busy/done handshake frames each run.
- A loadw-strobed summing stage registers the total of all channel counts for downstream datapath use.

Parameters:
- WIDTH, 4, bit width of each channel counter.
- NUM_CH, 2, number of channels (must be >= 2).
- LEN_W, 4, bit width of each per-channel run length and of the internal step counter.
- SATURATE, 0, 0 = counters wrap modulo 2^WIDTH; 1 = counters stick at all-ones.

Ports:
- clk  input  1  system clock; all state updates on the falling edge of clk.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new run; sampled on the falling edge.
- len  input  NUM_CH*LEN_W  packed run lengths; channel i occupies bits [i*LEN_W +: LEN_W]; captured only when start is accepted.
- loadw  input  1  when 1 at a falling edge, sum is updated; when 0, sum holds.
- count  output  NUM_CH*WIDTH  packed channel counter values, channel i at [i*WIDTH +: WIDTH].
- sum  output  SUM_W  registered sum of all channel counts, where SUM_W = WIDTH + clog2(NUM_CH).
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (async, immediate, mid-run included):
  - state = IDLE.
  - all count, sum, step, len_q and max_q = 0.
  - done = 0, busy = 0.
- States: IDLE, RUN, HOLD.
  - busy = (state == RUN), decoded from the state register.
- IDLE or HOLD with start = 1 at an edge:
  - Capture len into len_q; max_q = maximum of all len_q entries.
  - Clear all counters and step.
  - If max_q == 0: go to HOLD, done = 1 for the following cycle, counters stay 0, busy never asserts.
  - Otherwise go to RUN.
- RUN, each edge:
  - For every channel i with step < len_q[i], count_i increments by 1.
  - Channels with step >= len_q[i] hold their value.
  - step increments by 1.
  - When step + 1 == max_q: go to HOLD and set done = 1 for exactly one cycle.
- Run latency:
  - start accepted at edge N → first increment at edge N+1, last increment at edge N+max_q.
  - done is high and busy is low from edge N+max_q until edge N+max_q+1.
- Start during RUN is ignored; len changes are ignored outside capture.
- HOLD holds all counts until the next accepted start. HOLD re-accepts start exactly as IDLE does.
- Counter overflow:
  - SATURATE = 0: all-ones + 1 wraps to 0.
  - SATURATE = 1: counter stays at all-ones.
- Sum stage:
  - On an edge with loadw = 1: sum = zero-extended sum of all count values as they were before that edge. This is a registered value, not a latch.
  - SUM_W guarantees no overflow.
- loadw is independent of the FSM: legal in any state, including the same edge as a counter increment or a start capture, which use the pre-edge counts.
- done and start on the same edge (from HOLD): the restart is accepted; done still deasserts after one cycle.

Test Plan:
- NUM_CH=2, WIDTH=4, len ch0=9 ch1=4; start one cycle; then loadw=1 one cycle after done → count0=9, count1=4, busy high 9 cycles, done single pulse, sum=13.
- len ch0=20, LEN_W=5, WIDTH=4, SATURATE=0 → count0=4 at done; repeat with SATURATE=1 → count0=15.
- All len=0, start → busy never high, done pulses the cycle after start, counts 0.
- Start pulsed mid-run at step 3 → ignored, run completes unchanged. Start again in HOLD with len ch0=2 ch1=5 → counters restart from 0, end at 2 and 5.
- Assert rst asynchronously (between clock edges) at step 3 → count, sum, busy and done go to 0 immediately; FSM in IDLE; with loadw=0 afterwards, sum stays 0.
- loadw held high throughout a run with len ch0=3 ch1=1 → sum sequence per edge 0,2,3,4, each value lagging the counts by one edge.
